// File: rtl/z_pkg.sv
// rtl/z_pkg.sv - shared encodings and constants for the z_fetch instruction-fetch stage
package z_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  // Sticky fault causes reported on fault_code
  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_TIMEOUT  = 2'b10
  } fault_code_t;

  // Instruction presented before anything has been fetched
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Default address of the first fetch after reset
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Word alignment test for instruction addresses
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/z_fetch_timer.sv
// rtl/z_fetch_timer.sv - loadable up-counter with terminal-count flag, used for imem timeout
module z_fetch_timer #(
  parameter int unsigned W  = 5,
  parameter int unsigned TC = 15
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  // Counter: reset clears, load has priority over increment
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_tc = (r_count == W'(TC));

endmodule

// File: rtl/z_fetch.sv
// rtl/z_fetch.sv - instruction-fetch stage: PC, imem req/ready handshake, retire, sticky faults
module z_fetch
  import z_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_imem_req,
  output logic [31:0]      o_imem_addr,
  input  logic             i_imem_ready,
  input  logic [31:0]      i_imem_rdata,
  output logic [31:0]      o_inst,
  output logic [31:0]      o_pc,
  output logic             o_inst_valid,
  input  logic             i_stall,
  input  logic [31:0]      i_next_pc,
  output logic             o_fault,
  output logic [1:0]       o_fault_code,
  output logic [CNT_W-1:0] o_fetch_count
);

  // One extra bit so the timer can never wrap before the terminal count is seen
  localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_pc;
  logic [31:0]      r_inst;
  logic             r_valid;
  logic             r_req;
  logic [31:0]      r_addr;
  logic             r_fault;
  logic [1:0]       r_fault_code;
  logic [CNT_W-1:0] r_count;

  logic [31:0]      w_fetch_pc_nxt;
  logic [31:0]      w_pc_nxt;
  logic [31:0]      w_inst_nxt;
  logic             w_valid_nxt;
  logic             w_req_nxt;
  logic [31:0]      w_addr_nxt;
  logic             w_fault_nxt;
  logic [1:0]       w_fault_code_nxt;
  logic [CNT_W-1:0] w_count_nxt;

  logic             w_accept;
  logic             w_timeout;
  logic             w_retire;
  logic             w_next_aligned;
  logic             w_tmr_tc;
  logic             w_tmr_load;
  logic             w_tmr_en;

  // imem_ready only matters while a request is outstanding; stall only while holding an inst
  assign w_accept       = (r_state == S_REQ) && i_imem_ready;
  assign w_timeout      = (r_state == S_REQ) && !i_imem_ready && w_tmr_tc;
  assign w_retire       = (r_state == S_VALID) && !i_stall;
  assign w_next_aligned = is_word_aligned(i_next_pc);

  // Timer counts unanswered REQ cycles; it is parked at zero everywhere else
  assign w_tmr_load = (r_state != S_REQ) || i_imem_ready;
  assign w_tmr_en   = (r_state == S_REQ) && !i_imem_ready && !w_tmr_tc;

  z_fetch_timer #(
    .W  (TMR_W),
    .TC (TIMEOUT - 1)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_tmr_load),
    .i_load_val ('0),
    .i_en       (w_tmr_en),
    .o_tc       (w_tmr_tc)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (w_accept) begin
          w_state_nxt = S_VALID;
        end else if (w_timeout) begin
          w_state_nxt = S_FAULT;
        end
      end
      S_VALID: begin
        if (w_retire) begin
          w_state_nxt = w_next_aligned ? S_REQ : S_FAULT;
        end
      end
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs and fetch PC; anything not touched holds
  always_comb begin
    w_fetch_pc_nxt   = r_fetch_pc;
    w_pc_nxt         = r_pc;
    w_inst_nxt       = r_inst;
    w_valid_nxt      = r_valid;
    w_req_nxt        = r_req;
    w_addr_nxt       = r_addr;
    w_fault_nxt      = r_fault;
    w_fault_code_nxt = r_fault_code;
    w_count_nxt      = r_count;
    case (r_state)
      S_IDLE: begin
        w_req_nxt  = 1'b1;
        w_addr_nxt = r_fetch_pc;
      end
      S_REQ: begin
        if (w_accept) begin
          w_inst_nxt  = i_imem_rdata;
          w_pc_nxt    = r_fetch_pc;
          w_valid_nxt = 1'b1;
          w_req_nxt   = 1'b0;
        end else if (w_timeout) begin
          w_fault_nxt      = 1'b1;
          w_fault_code_nxt = FC_TIMEOUT;
          w_req_nxt        = 1'b0;
        end
      end
      S_VALID: begin
        if (w_retire) begin
          // The retiring instruction counts even if its successor address faults
          w_valid_nxt    = 1'b0;
          w_count_nxt    = r_count + CNT_W'(1);
          w_fetch_pc_nxt = i_next_pc;
          if (w_next_aligned) begin
            w_req_nxt  = 1'b1;
            w_addr_nxt = i_next_pc;
          end else begin
            w_fault_nxt      = 1'b1;
            w_fault_code_nxt = FC_MISALIGN;
          end
        end
      end
      S_FAULT: begin
        w_req_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_pc   <= RESET_PC;
      r_pc         <= RESET_PC;
      r_inst       <= NOP_WORD;
      r_valid      <= 1'b0;
      r_req        <= 1'b0;
      r_addr       <= RESET_PC;
      r_fault      <= 1'b0;
      r_fault_code <= FC_NONE;
      r_count      <= '0;
    end else begin
      r_fetch_pc   <= w_fetch_pc_nxt;
      r_pc         <= w_pc_nxt;
      r_inst       <= w_inst_nxt;
      r_valid      <= w_valid_nxt;
      r_req        <= w_req_nxt;
      r_addr       <= w_addr_nxt;
      r_fault      <= w_fault_nxt;
      r_fault_code <= w_fault_code_nxt;
      r_count      <= w_count_nxt;
    end
  end

  assign o_imem_req    = r_req;
  assign o_imem_addr   = r_addr;
  assign o_inst        = r_inst;
  assign o_pc          = r_pc;
  assign o_inst_valid  = r_valid;
  assign o_fault       = r_fault;
  assign o_fault_code  = r_fault_code;
  assign o_fetch_count = r_count;

endmodule
